sync_input_sequencer: RTL and testbench

Debounce and event-sequencing controller placed directly after the two-flop input synchronizer on the 11-bit board-input bus (switches/keys). It filters bounce by requiring a stable value for a programmable number of cycles, then commits the new value. Each committed change is queued as an event in a small show-ahead FIFO. Game logic consumes the events over a valid/ready handshake, so no input change is lost while that logic is busy.

---
 rtl/sync_input_sequencer.sv | 167 ++++++++++++++++
 tb/tb_sync_input_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sync_input_sequencer
// Purpose  : Debounces an already-synchronized board-input bus and queues each
//            committed change as an event in a small show-ahead FIFO that the
//            consumer drains over a valid/ready handshake.
// Ports    : clk        - system clock
//            reset      - synchronous, active-high reset
//            sync_in    - synchronized input bus
//            stable_out - current committed (debounced) value
//            evt_valid  - FIFO head event available
//            evt_ready  - consumer accepts head event
//            evt_data   - committed value carried by head event
//            evt_rise   - bits that went 0->1 in head event
//            overflow   - sticky: an event was dropped because FIFO was full
//            busy       - debounce in progress or events pending
// Revision : 1.0 - initial release
// ============================================================================
module sync_input_sequencer #(
  parameter int WIDTH         = 11,
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] stable_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_data,
  output logic [WIDTH-1:0] evt_rise,
  output logic             overflow,
  output logic             busy
);

  // cnt never exceeds STABLE_CYCLES-1: the commit happens at that value.
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   OCC_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   OCC_FULL  = (PTR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cand, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             commit;
  logic [WIDTH-1:0] commit_val;

  // --------------------------------------------------------------------------
  // Debounce FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cand       <= '0;
      cnt        <= '0;
      stable_out <= '0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
      if (commit) begin
        stable_out <= commit_val;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    cnt_nxt    = cnt;
    commit     = 1'b0;
    commit_val = cand;
    case (state)
      IDLE: begin
        if (sync_in != stable_out) begin
          if (STABLE_CYCLES == 1) begin
            commit     = 1'b1;
            commit_val = sync_in;
          end else begin
            cand_nxt  = sync_in;
            cnt_nxt   = CNT_ONE;
            state_nxt = CHECK;
          end
        end
      end
      CHECK: begin
        if (sync_in == cand) begin
          if (cnt == CNT_LAST) begin
            commit     = 1'b1;
            commit_val = cand;
            state_nxt  = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end else if (sync_in == stable_out) begin
          // Input bounced back to the committed value: drop the candidate.
          state_nxt = IDLE;
        end else begin
          // A third value appeared: restart the stability count on it.
          cand_nxt = sync_in;
          cnt_nxt  = CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Event FIFO (show-ahead, no bypass)
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [WIDTH-1:0] mem_rise [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   occ;
  logic             full, pop, do_push;

  assign full    = (occ == OCC_FULL);
  assign pop     = evt_valid && evt_ready;
  // A pop on the same edge frees the slot the push needs.
  assign do_push = commit && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_rise[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_data[wr_ptr] <= commit_val;
        mem_rise[wr_ptr] <= commit_val & ~stable_out;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (commit && !do_push) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  assign evt_valid = (occ != '0);
  assign evt_data  = mem_data[rd_ptr];
  assign evt_rise  = mem_rise[rd_ptr];
  assign busy      = (state == CHECK) || evt_valid;

endmodule
`default_nettype wire

// File: tb/tb_sync_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_input_sequencer
// Purpose  : Self-checking bench for sync_input_sequencer. A reference model
//            tracks run lengths of identical samples and a queue of expected
//            events; a monitor pops and compares whenever the DUT hands over
//            an event.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_input_sequencer;

  localparam int W      = 11;
  localparam int STABLE = 4;
  localparam int DEPTH  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sync_in;
  logic [W-1:0] stable_out;
  logic         evt_valid;
  logic         evt_ready;
  logic [W-1:0] evt_data;
  logic [W-1:0] evt_rise;
  logic         overflow;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  sync_input_sequencer #(
    .WIDTH(W), .STABLE_CYCLES(STABLE), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .sync_in(sync_in), .stable_out(stable_out),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_rise(evt_rise), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a value commits once it has been sampled STABLE times in
  // a row while differing from the committed value.
  // --------------------------------------------------------------------------
  logic [W-1:0]   m_stable;
  logic [W-1:0]   m_last;
  int             m_run;
  bit             m_ovf;
  bit             m_init = 1'b0;
  logic [2*W-1:0] exp_q[$];

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_stable = '0;
        m_last   = '0;
        m_run    = 0;
        m_ovf    = 1'b0;
        exp_q.delete();
        m_init   = 1'b1;
      end else if (m_init) begin
        if (m_run != 0 && sync_in == m_last) m_run++;
        else m_run = 1;
        m_last = sync_in;
        if (sync_in != m_stable && m_run >= STABLE) begin
          // The monitor already removed any entry leaving on this edge.
          if (exp_q.size() < DEPTH) exp_q.push_back({sync_in, sync_in & ~m_stable});
          else m_ovf = 1'b1;
          m_stable = sync_in;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: compares status every cycle and pops the expected queue whenever
  // an event is handed over on the coming edge.
  // --------------------------------------------------------------------------
  initial begin
    logic [2*W-1:0] e;
    bit             exp_busy;
    forever begin
      @(negedge clk);
      if (m_init) begin
        exp_busy = (m_run != 0 && m_last != m_stable) || (exp_q.size() != 0);
        check("evt_valid",  32'(evt_valid),  32'(exp_q.size() != 0));
        check("stable_out", 32'(stable_out), 32'(m_stable));
        check("overflow",   32'(overflow),   32'(m_ovf));
        check("busy",       32'(busy),       32'(exp_busy));
        if (exp_q.size() != 0 && evt_ready) begin
          e = exp_q.pop_front();
          check("evt_data", 32'(evt_data), 32'(e[2*W-1:W]));
          check("evt_rise", 32'(evt_rise), 32'(e[W-1:0]));
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic step(input logic [W-1:0] v, input logic rdy);
    sync_in   = v;
    evt_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [W-1:0] v, input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(v, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(sync_in, 1'b0);
    check("rst_evt_data", 32'(evt_data), 32'h0);
    check("rst_evt_rise", 32'(evt_rise), 32'h0);
    check("rst_stable",   32'(stable_out), 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] cur;
    int           hl;
    int           rmode;
    reset     = 1'b1;
    sync_in   = '0;
    evt_ready = 1'b0;
    hold('0, 1'b0, 3);
    do_reset();

    // Simple commit, consumer ready.
    hold(11'h005, 1'b1, 3);
    check("not_yet_committed", 32'(stable_out), 32'h000);
    hold(11'h005, 1'b1, 4);

    // Bounce rejected.
    do_reset();
    hold(11'h001, 1'b1, 2);
    hold(11'h000, 1'b1, 4);

    // Candidate change, then a falling-only change.
    hold(11'h001, 1'b1, 2);
    hold(11'h003, 1'b1, 6);
    hold(11'h7FF, 1'b1, 6);
    hold(11'h000, 1'b1, 6);

    // Overflow: five commits with the consumer stalled, then drain.
    do_reset();
    hold(11'h001, 1'b0, 5);
    hold(11'h002, 1'b0, 5);
    hold(11'h004, 1'b0, 5);
    hold(11'h008, 1'b0, 5);
    hold(11'h010, 1'b0, 5);
    check("ovf_sticky", 32'(overflow), 32'h1);
    hold(11'h010, 1'b1, 6);

    // Full FIFO with a pop on the very commit edge.
    do_reset();
    hold(11'h001, 1'b0, 5);
    hold(11'h002, 1'b0, 5);
    hold(11'h004, 1'b0, 5);
    hold(11'h008, 1'b0, 5);
    hold(11'h020, 1'b0, 3);
    step(11'h020, 1'b1);
    hold(11'h020, 1'b0, 2);
    check("full_pop_no_ovf", 32'(overflow), 32'h0);
    hold(11'h020, 1'b1, 6);

    // Reset mid-CHECK with two queued events.
    do_reset();
    hold(11'h011, 1'b0, 5);
    hold(11'h022, 1'b0, 5);
    hold(11'h0AA, 1'b0, 2);
    sync_in = 11'h0AA;
    do_reset();
    hold(11'h0AA, 1'b0, 3);
    check("fresh_count", 32'(stable_out), 32'h000);
    hold(11'h0AA, 1'b1, 5);

    // Randomized bursts.
    cur = '0;
    for (int b = 0; b < 400; b++) begin
      case ($urandom_range(0, 3))
        0:       cur = W'($urandom);
        1:       cur = cur ^ (W'(1) << $urandom_range(0, W - 1));
        default: ;
      endcase
      hl    = $urandom_range(1, 6);
      rmode = $urandom_range(0, 3);
      for (int h = 0; h < hl; h++) begin
        case (rmode)
          0:       step(cur, 1'b0);
          1:       step(cur, 1'b1);
          default: step(cur, 1'($urandom_range(0, 1)));
        endcase
      end
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    hold(cur, 1'b1, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
